// File: rtl/write_engine_pkg.sv
// rtl/write_engine_pkg.sv - shared FSM encodings and flow-control constants for write_engine
package write_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // avail_out is raised only while at least this many slots are free
   localparam int AVAIL_THRESHOLD = 2;

endpackage

// File: rtl/write_engine_if.sv
// rtl/write_engine_if.sv - upstream word stream and memory write port of write_engine
interface write_engine_if #(
   parameter int GROUP_SIZE      = 4,
   parameter int DATA_WIDTH      = 8,
   parameter int OUT_DATA_WIDTH  = 4,
   parameter int LOG_MAX_ADDRESS = 16
);
   logic [GROUP_SIZE*DATA_WIDTH-1:0]     data_in;
   logic                                 valid_in;
   logic                                 avail_out;
   logic [GROUP_SIZE*OUT_DATA_WIDTH-1:0] data_out;
   logic [LOG_MAX_ADDRESS-1:0]           address_out;
   logic                                 valid_out;
   logic                                 avail_in;

   // engine side
   modport slave (
      input  data_in, valid_in, avail_in,
      output avail_out, data_out, address_out, valid_out
   );

   // producer / memory-model side
   modport master (
      output data_in, valid_in, avail_in,
      input  avail_out, data_out, address_out, valid_out
   );
endinterface

// File: rtl/write_engine_fifo.sv
// rtl/write_engine_fifo.sv - input word buffer with occupancy count
module write_engine_fifo #(
   parameter int NUM_SLOTS     = 8,
   parameter int LOG_NUM_SLOTS = 3,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   input  logic                   rd_en,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   empty,
   output logic [LOG_NUM_SLOTS:0] count
);
   localparam logic [LOG_NUM_SLOTS-1:0] LAST_SLOT = LOG_NUM_SLOTS'(NUM_SLOTS - 1);
   localparam logic [LOG_NUM_SLOTS:0]   FULL_CNT  = (LOG_NUM_SLOTS+1)'(NUM_SLOTS);

   logic [DATA_WIDTH-1:0]    mem [NUM_SLOTS];
   logic [LOG_NUM_SLOTS-1:0] wr_ptr;
   logic [LOG_NUM_SLOTS-1:0] rd_ptr;
   logic                     full;
   logic                     push;
   logic                     pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign pop     = rd_en && !empty;
   // a push into a full buffer is only safe when a slot is freed in the same cycle
   assign push    = wr_en && (!full || pop);
   assign rd_data = mem[rd_ptr];

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + LOG_NUM_SLOTS'(1);
         if (pop)  rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + LOG_NUM_SLOTS'(1);
         case ({push, pop})
            2'b10:   count <= count + (LOG_NUM_SLOTS+1)'(1);
            2'b01:   count <= count - (LOG_NUM_SLOTS+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // storage array, contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/write_engine.sv
// rtl/write_engine.sv - strided clipping write engine; WRITE_ENGINE_SAT_COUNT_EN adds sat_count
module write_engine
   import write_engine_pkg::*;
#(
   parameter int GROUP_SIZE      = 4,
   parameter int DATA_WIDTH      = 8,
   parameter int OUT_DATA_WIDTH  = 4,
   parameter int LOG_MAX_ADDRESS = 16,
   parameter int FIFO_DEPTH      = 8,
   parameter int LOG_FIFO_DEPTH  = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       configure,
   input  logic [LOG_MAX_ADDRESS-1:0] base_address,
   input  logic [LOG_MAX_ADDRESS-1:0] stride,
   input  logic [LOG_MAX_ADDRESS-1:0] num_writes,
   input  logic [OUT_DATA_WIDTH-1:0]  min_clip,
   input  logic [OUT_DATA_WIDTH-1:0]  max_clip,
   input  logic                       signed_mode,
   write_engine_if.slave              bus,
   output logic                       busy,
   output logic                       done
`ifdef WRITE_ENGINE_SAT_COUNT_EN
   ,
   output logic [LOG_MAX_ADDRESS-1:0] sat_count
`endif
);
   localparam int                      WORD_W   = GROUP_SIZE * DATA_WIDTH;
   localparam logic [LOG_FIFO_DEPTH:0] DEPTH_C  = (LOG_FIFO_DEPTH+1)'(FIFO_DEPTH);
   localparam logic [LOG_FIFO_DEPTH:0] THRESH_C = (LOG_FIFO_DEPTH+1)'(AVAIL_THRESHOLD);

   state_t                              state;
   state_t                              state_next;
   logic                                pop;
   logic                                accept_cfg;
   logic [LOG_MAX_ADDRESS-1:0]          cur_addr;
   logic [LOG_MAX_ADDRESS-1:0]          remaining;
   logic [LOG_MAX_ADDRESS-1:0]          cfg_stride;
   logic [OUT_DATA_WIDTH-1:0]           cfg_min;
   logic [OUT_DATA_WIDTH-1:0]           cfg_max;
   logic                                cfg_signed;
   logic [WORD_W-1:0]                   fifo_rd_data;
   logic                                fifo_empty;
   logic [LOG_FIFO_DEPTH:0]             fifo_count;
   logic [GROUP_SIZE*OUT_DATA_WIDTH-1:0] clip_word;
`ifdef WRITE_ENGINE_SAT_COUNT_EN
   logic [GROUP_SIZE-1:0]               clip_flags;
   logic [LOG_MAX_ADDRESS:0]            sat_sum;
`endif

   write_engine_fifo #(
      .NUM_SLOTS     (FIFO_DEPTH),
      .LOG_NUM_SLOTS (LOG_FIFO_DEPTH),
      .DATA_WIDTH    (WORD_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.valid_in),
      .wr_data (bus.data_in),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign bus.avail_out = (DEPTH_C - fifo_count) >= THRESH_C;
   assign accept_cfg    = (state == ST_IDLE) && configure;
   assign busy          = (state != ST_IDLE);
   assign done          = (state == ST_DONE);

   // per-element clip against bounds widened to element width plus a sign guard bit
   for (genvar g = 0; g < GROUP_SIZE; g++) begin : g_clip
      logic [DATA_WIDTH-1:0]      elem;
      logic signed [DATA_WIDTH:0] x;
      logic signed [DATA_WIDTH:0] lo;
      logic signed [DATA_WIDTH:0] hi;
      logic [OUT_DATA_WIDTH-1:0]  y;

      assign elem = fifo_rd_data[g*DATA_WIDTH +: DATA_WIDTH];
      assign x    = {cfg_signed & elem[DATA_WIDTH-1], elem};
      assign lo   = {{(DATA_WIDTH+1-OUT_DATA_WIDTH){cfg_signed & cfg_min[OUT_DATA_WIDTH-1]}}, cfg_min};
      assign hi   = {{(DATA_WIDTH+1-OUT_DATA_WIDTH){cfg_signed & cfg_max[OUT_DATA_WIDTH-1]}}, cfg_max};

      // pick bound or truncated element
      always_comb begin
         if (x < lo)      y = cfg_min;
         else if (x > hi) y = cfg_max;
         else             y = elem[OUT_DATA_WIDTH-1:0];
      end

      assign clip_word[g*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = y;
`ifdef WRITE_ENGINE_SAT_COUNT_EN
      assign clip_flags[g] = (x < lo) || (x > hi);
`endif
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // next state and pop decision; RUN leaves once the last write has been issued
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (configure) state_next = (num_writes != '0) ? ST_RUN : ST_DONE;
         end
         ST_RUN: begin
            if (remaining == '0) state_next = ST_DONE;
            else                 pop = !fifo_empty && bus.avail_in;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // config latch, address generation and registered memory write port
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_addr        <= '0;
         remaining       <= '0;
         cfg_stride      <= '0;
         cfg_min         <= '0;
         cfg_max         <= '0;
         cfg_signed      <= 1'b0;
         bus.valid_out   <= 1'b0;
         bus.data_out    <= '0;
         bus.address_out <= '0;
      end else begin
         if (accept_cfg) begin
            cur_addr   <= base_address;
            remaining  <= num_writes;
            cfg_stride <= stride;
            cfg_min    <= min_clip;
            cfg_max    <= max_clip;
            cfg_signed <= signed_mode;
         end
         bus.valid_out <= pop;
         if (pop) begin
            bus.data_out    <= clip_word;
            bus.address_out <= cur_addr;
            cur_addr        <= cur_addr + cfg_stride;
            remaining       <= remaining - LOG_MAX_ADDRESS'(1);
         end
      end
   end

`ifdef WRITE_ENGINE_SAT_COUNT_EN
   // running total of clipped elements including the word being popped
   always_comb begin
      sat_sum = {1'b0, sat_count};
      for (int i = 0; i < GROUP_SIZE; i++) sat_sum = sat_sum + (LOG_MAX_ADDRESS+1)'(clip_flags[i]);
   end

   // saturating clip counter, restarted by each accepted job
   always_ff @(posedge clk) begin
      if (rst || accept_cfg) sat_count <= '0;
      else if (pop)          sat_count <= sat_sum[LOG_MAX_ADDRESS] ? '1 : sat_sum[LOG_MAX_ADDRESS-1:0];
   end
`endif
endmodule

// File: doc/write_engine.md
WRITE_ENGINE -- requirements
Module: write_engine

Interface
REQ-001 SHALL have parameter GROUP_SIZE, default 4: elements per word.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: input element width.
REQ-003 SHALL have parameter OUT_DATA_WIDTH, default 4: output element width, at most DATA_WIDTH.
REQ-004 SHALL have parameter LOG_MAX_ADDRESS, default 16: address width.
REQ-005 SHALL have parameters FIFO_DEPTH, default 8, and LOG_FIFO_DEPTH, default 3: input buffer slots.
REQ-006 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock; reset is synchronous and active-high.
REQ-007 SHALL have configure (in, 1): config strobe.
REQ-008 SHALL have base_address and stride (in, LOG_MAX_ADDRESS each): first address and address increment.
REQ-009 SHALL have num_writes (in, LOG_MAX_ADDRESS): writes per job.
REQ-010 SHALL have min_clip and max_clip (in, OUT_DATA_WIDTH each): clip bounds.
REQ-011 SHALL have signed_mode (in, 1): 1 means elements and bounds are two's complement.
REQ-012 SHALL have data_in (in, GROUP_SIZE*DATA_WIDTH), valid_in (in, 1) and avail_out (out, 1) as the upstream interface.
REQ-013 SHALL have data_out (out, GROUP_SIZE*OUT_DATA_WIDTH), address_out (out, LOG_MAX_ADDRESS), valid_out (out, 1) and avail_in (in, 1) as the memory interface.
REQ-014 SHALL have busy (out, 1) and done (out, 1): job active, and one-cycle job-complete pulse.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DONE.
REQ-016 On configure, IDLE SHALL latch all config inputs; it SHALL go to RUN if num_writes!=0, else to DONE.
REQ-017 configure in RUN or DONE SHALL be ignored.
REQ-018 In RUN, a pop SHALL occur when the FIFO is non-empty and avail_in=1; nothing SHALL be popped in IDLE or DONE.
REQ-019 Each pop SHALL register data_out, address_out and valid_out=1 on the next edge (1-cycle latency); valid_out SHALL otherwise be 0.
REQ-020 address_out SHALL be base+k*stride for the k-th write (k from 0), modulo 2^LOG_MAX_ADDRESS.
REQ-021 The remaining count SHALL decrement per pop; the pop that reaches 0 SHALL move the FSM to DONE.
REQ-022 DONE SHALL last one cycle, assert done, then return to IDLE; busy SHALL be 1 in RUN and DONE.
REQ-023 The FIFO SHALL accept valid_in writes in any state; words arriving early wait for a job.
REQ-024 avail_out SHALL be 1 only when at least 2 free slots exist; valid_in while full SHALL be dropped (upstream violation).
REQ-025 Simultaneous push and pop SHALL be legal at any occupancy, including full.
REQ-026 Each element SHALL be clipped to [min_clip, max_clip] and truncated to OUT_DATA_WIDTH.
REQ-027 Bounds SHALL be sign-extended when signed_mode=1 and zero-extended otherwise before comparison.
REQ-028 Equal bounds SHALL yield that constant; min>max is undefined.

Reset
REQ-029 On rst, the FSM SHALL go to IDLE and the FIFO SHALL be empty.
REQ-030 On rst, valid_out, done and busy SHALL be 0, and data_out and address_out SHALL be 0.
REQ-031 On rst, all latched config and counters SHALL be 0; reset mid-job SHALL abort the job with no further writes and no done.

Configuration
REQ-032 Macro WRITE_ENGINE_SAT_COUNT_EN SHALL add output sat_count (LOG_MAX_ADDRESS).
REQ-033 When the macro is defined, sat_count SHALL count, per popped word, the elements that were clipped.
REQ-034 sat_count SHALL saturate at all-ones, clear on reset and clear on an accepted configure.
REQ-035 Without the macro, the port and its logic SHALL be absent and behaviour otherwise identical.

Structure
REQ-036 The FSM state encodings and the avail threshold constant (2) SHALL live in the shared header RTLinf.vh.
REQ-037 The buffer SHALL be an instance of the existing FIFO sub-module (NUM_SLOTS=FIFO_DEPTH, DATA_WIDTH=GROUP_SIZE*DATA_WIDTH); the clip path SHALL stay inline.

Verification
REQ-038 Base test: base=100, stride=1, num=4, four words pushed with avail_in=1 -> addresses 100..103 on consecutive cycles, done one cycle after the last valid_out.
REQ-039 Stride wrap test: LOG_MAX_ADDRESS=16, base=0xFFFE, stride=3, num=3 -> addresses 0xFFFE, 0x0001, 0x0004.
REQ-040 Clip test: signed_mode=1, min=-4, max=3, elements 0x7F, 0x80, 0x02, 0xFC -> outputs 3, -4, 2, -4; with the macro, sat_count=2.
REQ-041 Backpressure test: avail_in toggling 1,0,0,1, FIFO filled to FIFO_DEPTH -> no valid_out after an avail_in=0 cycle, avail_out=0 at FIFO_DEPTH-1 entries, no data lost.
REQ-042 num_writes=0 test -> done one cycle after configure, no valid_out; a second configure during RUN -> ignored.
REQ-043 Reset test: rst asserted after 2 of 5 writes -> valid_out=0 next cycle, busy=0, no done pulse.
